// File: rtl/cu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : cu_sequencer
//  Purpose  : Control-unit sequencer. Selects the fetch or execute control
//             word from the current state, stalls on memory wait, owns the
//             instruction and status registers, and latches a sticky halt.
//  Options  : CU_PERF_CNT_EN - adds the 16-bit instr_count output counting
//             committed instruction-register loads.
//  Revision : 1.0 - initial release
// ============================================================================
module cu_sequencer (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [35:0] ifetch_cw,
  input  logic [2:0]  ifetch_ns,
  input  logic [35:0] exec_cw,
  input  logic [2:0]  exec_ns,
  input  logic [31:0] mem_data,
  input  logic        mem_ready,
  input  logic [3:0]  alu_status,
  output logic [35:0] cw_out,
  output logic [2:0]  state,
  output logic        halted,
  output logic        stall,
  output logic        pc_en,
  output logic [31:0] ir_out,
  output logic [10:0] opcode,
  output logic [3:0]  status
`ifdef CU_PERF_CNT_EN
  ,
  output logic [15:0] instr_count
`endif
);

  localparam logic [2:0] FETCH = 3'b000;
  localparam logic [2:0] HALT  = 3'b111;

  // Control-word bit positions used by the sequencer itself.
  localparam int BIT_W_REG       = 13;
  localparam int BIT_MEM_CS      = 11;
  localparam int BIT_IR_LOAD     = 8;
  localparam int BIT_STATUS_LOAD = 7;

  // Reserved bits [35:34] are never driven onto the datapath.
  localparam logic [35:0] RSV_CLR_MASK = 36'h3_FFFF_FFFF;
  // Register-writing strobes suppressed while waiting on memory.
  localparam logic [35:0] STALL_CLR_MASK = ~((36'd1 << BIT_W_REG) |
                                             (36'd1 << BIT_IR_LOAD) |
                                             (36'd1 << BIT_STATUS_LOAD));

  logic [35:0] sel_cw;
  logic [2:0]  sel_ns;
  logic [35:0] gate_mask;
  logic        advance;
  logic        ir_commit;
  logic        status_commit;

  // Word/next-state selection, stall detection and output gating.
  always_comb begin
    sel_cw    = exec_cw;
    sel_ns    = exec_ns;
    if (state == FETCH) begin
      sel_cw = ifetch_cw;
      sel_ns = ifetch_ns;
    end
    stall     = sel_cw[BIT_MEM_CS] & ~mem_ready & ~halted;
    gate_mask = RSV_CLR_MASK;
    if (stall) begin
      gate_mask = gate_mask & STALL_CLR_MASK;
    end
    if (halted) begin
      gate_mask = '0;
    end
    cw_out        = sel_cw & gate_mask;
    pc_en         = ~stall & ~halted;
    advance       = ~stall & ~halted;
    // Strobes are taken from the gated word so stall/halt suppress them.
    ir_commit     = cw_out[BIT_IR_LOAD];
    status_commit = cw_out[BIT_STATUS_LOAD];
  end

  assign opcode = ir_out[31:21];

  // State register and sticky halt; holds while stalled or halted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= FETCH;
      halted <= 1'b0;
    end else if (advance) begin
      state <= sel_ns;
      if (sel_ns == HALT) begin
        halted <= 1'b1;
      end
    end
  end

  // Instruction register captures the memory bus on a committed IR load.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ir_out <= '0;
    end else if (ir_commit) begin
      ir_out <= mem_data;
    end
  end

  // Status register captures ALU flags on a committed status load.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      status <= '0;
    end else if (status_commit) begin
      status <= alu_status;
    end
  end

`ifdef CU_PERF_CNT_EN
  // Committed instruction counter, wraps naturally at 16 bits.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      instr_count <= '0;
    end else if (ir_commit) begin
      instr_count <= instr_count + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cu_sequencer
//  Purpose  : Directed self-checking bench for cu_sequencer. The instruction
//             counter section is compiled only with CU_PERF_CNT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cu_sequencer;

  localparam logic [35:0] B_WREG = 36'h0_0000_2000;
  localparam logic [35:0] B_MCS  = 36'h0_0000_0800;
  localparam logic [35:0] B_MEMW = 36'h0_0000_0200;
  localparam logic [35:0] B_IR   = 36'h0_0000_0100;
  localparam logic [35:0] B_ST   = 36'h0_0000_0080;
  localparam logic [35:0] B_SIZE = 36'h0_0000_0060;
  localparam logic [35:0] B_RSV  = 36'hC_0000_0000;
  localparam logic [35:0] B_FS   = 36'h3_E000_0000;
  localparam logic [35:0] B_PCFS = 36'h0_0000_0001;

  logic        clock;
  logic        reset_n;
  logic [35:0] ifetch_cw;
  logic [2:0]  ifetch_ns;
  logic [35:0] exec_cw;
  logic [2:0]  exec_ns;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic [3:0]  alu_status;
  logic [35:0] cw_out;
  logic [2:0]  state;
  logic        halted;
  logic        stall;
  logic        pc_en;
  logic [31:0] ir_out;
  logic [10:0] opcode;
  logic [3:0]  status;
`ifdef CU_PERF_CNT_EN
  logic [15:0] instr_count;
`endif

  int errors = 0;
  int checks = 0;

  cu_sequencer dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .ifetch_cw  (ifetch_cw),
    .ifetch_ns  (ifetch_ns),
    .exec_cw    (exec_cw),
    .exec_ns    (exec_ns),
    .mem_data   (mem_data),
    .mem_ready  (mem_ready),
    .alu_status (alu_status),
    .cw_out     (cw_out),
    .state      (state),
    .halted     (halted),
    .stall      (stall),
    .pc_en      (pc_en),
    .ir_out     (ir_out),
    .opcode     (opcode),
    .status     (status)
`ifdef CU_PERF_CNT_EN
    ,
    .instr_count(instr_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected datapath word: reserved bits cleared, write strobes cleared on stall.
  function automatic logic [35:0] exp_cw(input logic [35:0] cw, input logic stl);
    logic [35:0] r;
    r = cw & ~B_RSV;
    if (stl) r = r & ~(B_WREG | B_IR | B_ST);
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n    = 1'b0;
    ifetch_cw  = '0;
    ifetch_ns  = 3'b000;
    exec_cw    = '0;
    exec_ns    = 3'b000;
    mem_data   = '0;
    mem_ready  = 1'b1;
    alu_status = 4'b0000;

    // Reset state
    #12;
    check("rst_state", {33'd0, state}, 36'd0);
    check("rst_halted", {35'd0, halted}, 36'd0);
    check("rst_ir", {4'd0, ir_out}, 36'd0);
    check("rst_status", {32'd0, status}, 36'd0);

    // First fetch: IR load with memory ready
    ifetch_cw = B_RSV | B_FS | B_MCS | B_IR | B_PCFS;
    ifetch_ns = 3'b001;
    mem_data  = 32'h8B02_0020;
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("f0_cw", cw_out, exp_cw(ifetch_cw, 1'b0));
    check("f0_pc_en", {35'd0, pc_en}, 36'd1);
    check("f0_stall", {35'd0, stall}, 36'd0);
    tick();
    check("f1_state", {33'd0, state}, 36'd1);
    check("f1_opcode", {25'd0, opcode}, 36'h458);
    check("f1_ir", {4'd0, ir_out}, 36'h8B02_0020);

    // Execute: status load, then hold when not loading
    exec_cw    = B_ST | B_WREG;
    exec_ns    = 3'b001;
    alu_status = 4'b0101;
    #1;
    check("e_cw", cw_out, exp_cw(exec_cw, 1'b0));
    tick();
    check("e_status", {32'd0, status}, 36'h5);
    check("e_state", {33'd0, state}, 36'd1);
    exec_cw    = B_WREG;
    alu_status = 4'b1010;
    tick();
    check("e_status_hold", {32'd0, status}, 36'h5);

    // Both loads in one cycle, return to fetch
    exec_cw    = B_MCS | B_IR | B_ST;
    exec_ns    = 3'b000;
    mem_data   = 32'h1234_5678;
    alu_status = 4'b0011;
    tick();
    check("both_ir", {4'd0, ir_out}, 36'h1234_5678);
    check("both_status", {32'd0, status}, 36'h3);
    check("both_state", {33'd0, state}, 36'd0);

    // Fetch stalled three cycles, then completes
    ifetch_cw  = B_RSV | B_MCS | B_IR | B_ST | B_WREG | B_MEMW | B_SIZE;
    ifetch_ns  = 3'b010;
    mem_ready  = 1'b0;
    mem_data   = 32'hCAFE_F00D;
    alu_status = 4'b1100;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("stl%0d_stall", i), {35'd0, stall}, 36'd1);
      check($sformatf("stl%0d_pc_en", i), {35'd0, pc_en}, 36'd0);
      check($sformatf("stl%0d_cw", i), cw_out, exp_cw(ifetch_cw, 1'b1));
      tick();
      check($sformatf("stl%0d_state", i), {33'd0, state}, 36'd0);
      check($sformatf("stl%0d_ir", i), {4'd0, ir_out}, 36'h1234_5678);
    end
    mem_ready = 1'b1;
    #1;
    check("stl_done_cw", cw_out, exp_cw(ifetch_cw, 1'b0));
    check("stl_done_pc_en", {35'd0, pc_en}, 36'd1);
    tick();
    check("stl_done_state", {33'd0, state}, 36'd2);
    check("stl_done_ir", {4'd0, ir_out}, 36'hCAFE_F00D);
    check("stl_done_status", {32'd0, status}, 36'hC);

    // Asynchronous reset during an execute-phase stall
    exec_cw   = B_MCS | B_IR;
    exec_ns   = 3'b011;
    mem_ready = 1'b0;
    #1;
    check("xs_stall", {35'd0, stall}, 36'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check("xs_rst_state", {33'd0, state}, 36'd0);
    check("xs_rst_ir", {4'd0, ir_out}, 36'd0);
    check("xs_rst_status", {32'd0, status}, 36'd0);
    ifetch_cw = B_RSV | B_FS | B_MEMW | B_PCFS;
    ifetch_ns = 3'b001;
    mem_ready = 1'b1;
    reset_n   = 1'b1;
    #1;
    check("xs_rel_cw", cw_out, exp_cw(ifetch_cw, 1'b0));

    // Halt from execute
    tick();
    check("h_exec_state", {33'd0, state}, 36'd1);
    exec_cw    = B_FS | B_WREG;
    exec_ns    = 3'b111;
    tick();
    check("h_halted", {35'd0, halted}, 36'd1);
    check("h_state", {33'd0, state}, 36'd7);
    check("h_cw", cw_out, 36'd0);
    check("h_pc_en", {35'd0, pc_en}, 36'd0);
    exec_cw    = B_MCS | B_IR | B_ST;
    exec_ns    = 3'b001;
    mem_ready  = 1'b0;
    mem_data   = 32'hDEAD_BEEF;
    alu_status = 4'b1111;
    #1;
    check("h_stall", {35'd0, stall}, 36'd0);
    check("h_cw2", cw_out, 36'd0);
    tick();
    check("h_hold_state", {33'd0, state}, 36'd7);
    check("h_hold_halted", {35'd0, halted}, 36'd1);
    check("h_hold_ir", {4'd0, ir_out}, 36'd0);
    check("h_hold_status", {32'd0, status}, 36'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check("h_rst_state", {33'd0, state}, 36'd0);
    check("h_rst_halted", {35'd0, halted}, 36'd0);
    reset_n = 1'b1;

`ifdef CU_PERF_CNT_EN
    // Instruction counter: wrap and stall hold
    check("cnt_rst", {20'd0, instr_count}, 36'd0);
    ifetch_cw = B_MCS | B_IR;
    ifetch_ns = 3'b000;
    mem_ready = 1'b1;
    repeat (65535) @(posedge clock);
    #1;
    check("cnt_ffff", {20'd0, instr_count}, 36'hFFFF);
    tick();
    check("cnt_wrap", {20'd0, instr_count}, 36'h0);
    mem_ready = 1'b0;
    tick();
    check("cnt_stall", {20'd0, instr_count}, 36'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cu_sequencer.md
CU_SEQUENCER -- requirements
Module: cu_sequencer

Interface
REQ-001 SHALL provide clock  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL provide reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL provide ifetch_cw  input  36  fetch-phase control word; ifetch_ns  input  3  fetch-phase next state.
REQ-004 SHALL provide exec_cw  input  36  execute-phase control word; exec_ns  input  3  execute-phase next state.
REQ-005 SHALL provide mem_data  input  32  instruction word from memory data bus; mem_ready  input  1  memory access complete.
REQ-006 SHALL provide alu_status  input  4  ALU flags {N,Z,C,V}.
REQ-007 SHALL provide cw_out  output  36  active control word to datapath.
REQ-008 SHALL provide state  output  3  current sequencer state; halted  output  1  sticky halt flag; stall  output  1  memory wait; pc_en  output  1  PC update permitted.
REQ-009 SHALL provide ir_out  output  32  instruction register; opcode  output  11  ir_out[31:21]; status  output  4  status register.
REQ-010 Control word layout SHALL be: [35:34] reserved, FS[33:29], SA[28:24], SB[23:19], DA[18:14], w_reg[13], C0[12], mem_cs[11], B_Sel[10], mem_w[9], IR_load[8], status_load[7], size[6:5], add_tri_sel[4], data_tri_sel[3], PC_sel[2], PC_FS[1:0].

Function
REQ-011 State 3'b000 SHALL be FETCH; selected word = ifetch_cw, next = ifetch_ns; any other state selects exec_cw, exec_ns.
REQ-012 cw_out SHALL be combinational from current state, mem_ready and halted; state register SHALL load next state on the rising edge (1-cycle latency per state).
REQ-013 stall SHALL equal selected mem_cs AND NOT mem_ready AND NOT halted.
REQ-014 During stall, state SHALL hold, and cw_out w_reg, IR_load, status_load SHALL be forced 0; mem_cs, mem_w, address/size fields SHALL pass unchanged.
REQ-015 pc_en SHALL equal NOT stall AND NOT halted.
REQ-016 ir_out SHALL load mem_data on the edge where committed IR_load=1; new opcode visible the following cycle.
REQ-017 status SHALL load alu_status on the edge where committed status_load=1; otherwise hold.
REQ-018 IR_load and status_load committed in the same cycle SHALL both take effect.
REQ-019 Next state 3'b111 SHALL set halted on that edge; state SHALL then hold 3'b111.
REQ-020 While halted, cw_out SHALL be all zeros, pc_en 0, stall 0, ir_out/status hold; only reset clears halted.
REQ-021 Reserved bits [35:34] of cw_out SHALL always be 0.

Reset
REQ-022 reset_n low SHALL immediately force state=000, halted=0, ir_out=0, status=0 (and instr_count=0 when present), regardless of clock.
REQ-023 Reset asserted mid-stall or mid-execute SHALL abandon the operation; first cycle after release SHALL present ifetch_cw.

Configuration
REQ-024 Macro CU_PERF_CNT_EN SHALL, when defined, add output instr_count  16  count of committed IR loads.
REQ-025 With CU_PERF_CNT_EN, instr_count SHALL increment by 1 per committed IR_load, wrap 16'hFFFF to 16'h0000, and hold while halted or stalled.
REQ-026 Without CU_PERF_CNT_EN, port and counter logic SHALL be absent; all other behaviour identical.

Verification
REQ-027 Reset, ifetch_ns=001, IR_load=1, mem_cs=1, mem_ready=1, mem_data=32'h8B020020 -> cycle 1 state=001, opcode=11'h458, pc_en=1 in cycle 0.
REQ-028 FETCH with mem_ready=0 for 3 cycles then 1 -> state held 000, stall=1, cw_out[8]=0, pc_en=0 for 3 cycles; IR loads on 4th edge.
REQ-029 State 001, exec_cw status_load=1, alu_status=4'b0101 -> status=4'b0101 next cycle; status unchanged when status_load=0.
REQ-030 exec_ns=111 -> halted=1, cw_out=0 next cycle and thereafter; reset_n pulse low -> state=000, halted=0 asynchronously.
REQ-031 CU_PERF_CNT_EN defined, preload via 65535 fetches -> instr_count=16'hFFFF; one more fetch -> 16'h0000; stalled fetch -> no increment.
REQ-032 reset_n asserted between clock edges during stall -> outputs reset before next edge; after release cw_out equals ifetch_cw.
